// File: rtl/fme_carregador_janela.sv
// Reference-window loader: fetches 4 memory words per row, assembles 32 pixels
// and hands each row to the FME interpolator over a valid/ready handshake.
module fme_carregador_janela #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int ROWS       = 40
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ADDR_WIDTH-1:0]   stride,
    output logic                    mem_rd,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [8*DATA_WIDTH-1:0] mem_rdata,
    output logic [32*DATA_WIDTH-1:0] row_data,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic                    interp_enable,
    input  logic                    interp_done,
    output logic                    busy,
    output logic                    done
);
    localparam int         WORD_W   = 8 * DATA_WIDTH;
    localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_PRESENT,
        S_WAIT_INT,
        S_FINISH
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_row_addr;
    logic [ADDR_WIDTH-1:0]   r_stride;
    logic [7:0]              r_row_cnt;
    logic [1:0]              r_word;
    logic                    r_mem_rd;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic                    r_cap_valid;
    logic [1:0]              r_cap_idx;
    logic [32*DATA_WIDTH-1:0] r_row_data;
    logic                    r_row_valid;
    logic                    r_interp_enable;
    logic                    r_busy;
    logic                    r_done;

    logic [1:0]              w_next_word;
    logic [ADDR_WIDTH-1:0]   w_word_addr;
    logic [ADDR_WIDTH-1:0]   w_next_row;

    assign w_next_word = r_word + 2'd1;
    assign w_word_addr = r_row_addr + ADDR_WIDTH'(w_next_word);
    assign w_next_row  = r_row_addr + r_stride;

    // Busy and done are held one extra cycle past FINISH so the done pulse
    // lands two cycles after interp_done and busy falls together with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_row_addr      <= '0;
            r_stride        <= '0;
            r_row_cnt       <= '0;
            r_word          <= '0;
            r_mem_rd        <= 1'b0;
            r_mem_addr      <= '0;
            r_row_valid     <= 1'b0;
            r_interp_enable <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_row_addr <= base_addr;
                        r_stride   <= stride;
                        r_row_cnt  <= '0;
                        r_word     <= '0;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= base_addr;
                        r_busy     <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (r_word == 2'd3) begin
                        r_mem_rd <= 1'b0;
                        r_state  <= S_LAST;
                    end else begin
                        r_word     <= w_next_word;
                        r_mem_addr <= w_word_addr;
                    end
                end
                S_LAST: begin
                    r_row_valid     <= 1'b1;
                    r_interp_enable <= 1'b1;
                    r_state         <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (row_ready) begin
                        r_row_valid <= 1'b0;
                        if (r_row_cnt == LAST_ROW) begin
                            r_state <= S_WAIT_INT;
                        end else begin
                            r_row_cnt  <= r_row_cnt + 8'd1;
                            r_row_addr <= w_next_row;
                            r_mem_addr <= w_next_row;
                            r_word     <= '0;
                            r_mem_rd   <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_WAIT_INT: begin
                    if (interp_done) begin
                        r_interp_enable <= 1'b0;
                        r_state         <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read data returns one cycle after the strobe, so the word index of each
    // read is delayed alongside it to steer the data into its pixel slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cap_valid <= 1'b0;
            r_cap_idx   <= '0;
            r_row_data  <= '0;
        end else begin
            r_cap_valid <= r_mem_rd;
            r_cap_idx   <= r_word;
            if (r_cap_valid) begin
                r_row_data[int'(r_cap_idx)*WORD_W +: WORD_W] <= mem_rdata;
            end
        end
    end

    assign mem_rd        = r_mem_rd;
    assign mem_addr      = r_mem_addr;
    assign row_data      = r_row_data;
    assign row_valid     = r_row_valid;
    assign interp_enable = r_interp_enable;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_fme_carregador_janela.sv
// Scoreboard bench for the window loader: one ROWS=2 instance under random and
// directed jobs, plus a ROWS=1 instance for the minimum-latency timeline.
module tb_fme_carregador_janela;
    localparam int DW = 8;
    localparam int AW = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic            aStart, aMemRd, aValid, aReady, aEnable, aIntDone, aBusy, aDone;
    logic [AW-1:0]   aBase, aStride, aMemAddr;
    logic [8*DW-1:0] aMemRdata;
    logic [32*DW-1:0] aRowData;

    logic            bStart, bMemRd, bValid, bReady, bEnable, bIntDone, bBusy, bDone;
    logic [AW-1:0]   bBase, bStride, bMemAddr;
    logic [8*DW-1:0] bMemRdata;
    logic [32*DW-1:0] bRowData;

    fme_carregador_janela #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROWS(2)) dutA (
        .clock(clock), .reset(reset), .start(aStart), .base_addr(aBase), .stride(aStride),
        .mem_rd(aMemRd), .mem_addr(aMemAddr), .mem_rdata(aMemRdata),
        .row_data(aRowData), .row_valid(aValid), .row_ready(aReady),
        .interp_enable(aEnable), .interp_done(aIntDone), .busy(aBusy), .done(aDone)
    );

    fme_carregador_janela #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROWS(1)) dutB (
        .clock(clock), .reset(reset), .start(bStart), .base_addr(bBase), .stride(bStride),
        .mem_rd(bMemRd), .mem_addr(bMemAddr), .mem_rdata(bMemRdata),
        .row_data(bRowData), .row_valid(bValid), .row_ready(bReady),
        .interp_enable(bEnable), .interp_done(bIntDone), .busy(bBusy), .done(bDone)
    );

    // Memory contents: every byte of every word is distinct so that lane or
    // word misplacement shows up in the assembled row.
    function automatic logic [63:0] memWord(input logic [15:0] a);
        logic [63:0] v;
        for (int j = 0; j < 8; j++) v[j*8 +: 8] = a[7:0] + a[15:8] + 8'(37 * j + 1);
        return v;
    endfunction

    function automatic logic [15:0] modelAddr(input logic [15:0] base, input logic [15:0] str,
                                              input int r, input int w);
        return 16'(int'(base) + r * int'(str) + w);
    endfunction

    function automatic logic [255:0] modelRow(input logic [15:0] base, input logic [15:0] str,
                                              input int r);
        logic [255:0] row;
        logic [63:0]  word;
        for (int w = 0; w < 4; w++) begin
            word = memWord(modelAddr(base, str, r, w));
            for (int j = 0; j < 8; j++) row[(8*w + j)*8 +: 8] = word[j*8 +: 8];
        end
        return row;
    endfunction

    always @(posedge clock) if (aMemRd) aMemRdata <= memWord(aMemAddr);
    always @(posedge clock) if (bMemRd) bMemRdata <= memWord(bMemAddr);

    logic [15:0]  expAddrQ[$];
    logic [255:0] expRowQ[$];
    bit           monOn = 1'b0;
    int           readyMode = 0;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ready driver: always ready, random, or held low ten cycles per row.
    int lowCnt = 0;
    always @(posedge clock) begin
        #1;
        case (readyMode)
            1: aReady = 1'($urandom_range(0, 1));
            2: begin
                if (!aValid) begin
                    lowCnt = 0;
                    aReady = 1'b0;
                end else if (lowCnt < 10) begin
                    lowCnt++;
                    aReady = 1'b0;
                end else begin
                    aReady = 1'b1;
                end
            end
            default: aReady = 1'b1;
        endcase
    end

    // Monitor: pops expected reads and rows as the DUT presents them.
    logic [15:0] expAddr;
    always @(negedge clock) begin
        if (!reset && monOn) begin
            if (aMemRd) begin
                if (expAddrQ.size() == 0) checkOutput("unexpected mem_rd", {240'd0, aMemAddr}, 256'hDEAD);
                else begin
                    expAddr = expAddrQ.pop_front();
                    checkOutput("mem_addr", {240'd0, aMemAddr}, {240'd0, expAddr});
                end
            end
            if (aValid) begin
                checkOutput("mem_rd while row_valid", {255'd0, aMemRd}, 256'd0);
                if (expRowQ.size() == 0) checkOutput("unexpected row_valid", aRowData, 256'hDEAD);
                else begin
                    checkOutput("row_data", aRowData, expRowQ[0]);
                    if (aReady) void'(expRowQ.pop_front());
                end
            end
        end
    end

    // One ROWS=2 job; cycle k observes values sampled at edge t+k.
    task automatic applyStimulus(input logic [15:0] base, input logic [15:0] str, input int mode,
                                 input int doneDelay, input bit pokeStart, input bit pokeDone);
        int  hs = 0, lastHsK = 0, doneAt = 0;
        bit  prevValid = 1'b0, finished = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 4; w++) expAddrQ.push_back(modelAddr(base, str, r, w));
            expRowQ.push_back(modelRow(base, str, r));
        end
        readyMode = mode;
        @(posedge clock); #1;
        aBase = base; aStride = str; aStart = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clock); #1;
            if (k == 1) begin
                aStart = 1'b0;
                aBase = 16'($urandom);
                aStride = 16'($urandom);
            end
            if (pokeStart) aStart = (k == 3);
            aIntDone = (doneAt != 0 && k == doneAt) || (pokeDone && k == 6);
            @(negedge clock);
            if (aValid && !prevValid) begin
                if (hs == 0) checkOutput("first row_valid latency", 256'(k), 256'd6);
                else checkOutput("row_valid after handshake", 256'(k - lastHsK), 256'd6);
            end
            prevValid = aValid;
            checkOutput("busy", {255'd0, aBusy}, {255'd0, (doneAt == 0 || k <= doneAt + 2)});
            checkOutput("interp_enable", {255'd0, aEnable}, {255'd0, (k >= 6 && (doneAt == 0 || k <= doneAt))});
            checkOutput("done", {255'd0, aDone}, {255'd0, (doneAt != 0 && k == doneAt + 2)});
            if (aValid && aReady) begin
                hs++;
                lastHsK = k;
                if (hs == 2) doneAt = k + 1 + doneDelay;
            end
            if (doneAt != 0 && k == doneAt + 3) begin
                finished = 1'b1;
                break;
            end
        end
        aIntDone = 1'b0;
        if (!finished) begin
            checkOutput("job timeout", 256'd0, 256'd1);
            reset = 1'b1; #2; reset = 1'b0;
        end
        checkOutput("reads outstanding", 256'(expAddrQ.size()), 256'd0);
        checkOutput("rows outstanding", 256'(expRowQ.size()), 256'd0);
        expAddrQ.delete();
        expRowQ.delete();
    endtask

    initial begin
        reset = 1'b1;
        aStart = 0; aBase = 0; aStride = 0; aIntDone = 0; aReady = 1;
        bStart = 0; bBase = 16'h4321; bStride = 16'h0010; bIntDone = 1; bReady = 1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset busy",      {255'd0, aBusy},  256'd0);
        checkOutput("reset row_valid", {255'd0, aValid}, 256'd0);
        checkOutput("reset mem_rd",    {255'd0, aMemRd}, 256'd0);
        checkOutput("reset row_data",  aRowData,         256'd0);
        checkOutput("reset B done",    {255'd0, bDone},  256'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        monOn = 1'b1;

        applyStimulus(16'h0010, 16'h0004, 0, 2, 0, 0);
        applyStimulus(16'h0200, 16'h0040, 2, 0, 0, 0);
        applyStimulus(16'hFFFE, 16'h0002, 0, 1, 0, 0);
        applyStimulus(16'h0300, 16'h0008, 1, 1, 1, 1);

        // Abort during LAST of the second row, then confirm a clean restart.
        readyMode = 0;
        @(posedge clock); #1;
        aBase = 16'h1234; aStride = 16'h0100; aStart = 1'b1;
        monOn = 1'b0;
        @(posedge clock); #1;
        aStart = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock); #1;
        reset = 1'b1;
        #1;
        checkOutput("abort mem_rd",        {255'd0, aMemRd},  256'd0);
        checkOutput("abort mem_addr",      {240'd0, aMemAddr}, 256'd0);
        checkOutput("abort row_valid",     {255'd0, aValid},  256'd0);
        checkOutput("abort row_data",      aRowData,          256'd0);
        checkOutput("abort interp_enable", {255'd0, aEnable}, 256'd0);
        checkOutput("abort busy",          {255'd0, aBusy},   256'd0);
        checkOutput("abort done",          {255'd0, aDone},   256'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        monOn = 1'b1;
        applyStimulus(16'h0ABC, 16'h0020, 0, 0, 0, 0);

        // ROWS=1 instance with ready and interp_done held high.
        @(posedge clock); #1;
        bStart = 1'b1;
        @(posedge clock); #1;
        bStart = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            checkOutput("min busy",      {255'd0, bBusy},   {255'd0, (k <= 9)});
            checkOutput("min done",      {255'd0, bDone},   {255'd0, (k == 9)});
            checkOutput("min row_valid", {255'd0, bValid},  {255'd0, (k == 6)});
            checkOutput("min enable",    {255'd0, bEnable}, {255'd0, (k == 6 || k == 7)});
            if (k == 6) checkOutput("min row_data", bRowData, modelRow(16'h4321, 16'h0010, 0));
        end

        repeat (10) begin
            applyStimulus(16'($urandom), 16'($urandom), $urandom_range(0, 2),
                          $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
